lsu_mem_master: RTL and testbench
=================================

Name: lsu_mem_master

Overview:
- Load/store unit that issues word transactions to the word-addressed data Memory block (combinational read, posedge write, single word write enable).
- Supports all RV32I load/store widths; sub-word stores use read-modify-write because the memory has no byte enables.
- Sits in the MEM stage. A one-outstanding req/resp handshake to the pipeline stalls the pipeline until resp_valid is seen.

Parameters:
- MEM_WORDS_LOG2, 8, log2 of memory depth in words; word index is addr[MEM_WORDS_LOG2+1:2].
- CHECK_RANGE, 1, when 1, a nonzero addr[31:MEM_WORDS_LOG2+2] is an access error.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  unit idle and able to accept a request.
- req_we  input  1  1=store, 0=load.
- req_funct3  input  3  RV32I width/sign: 0=B, 1=H, 2=W, 4=BU, 5=HU.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; low byte/half used for SB/SH.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  load result, extended per funct3; 0 for stores and errors.
- resp_err  output  1  misaligned, illegal funct3, or out-of-range access; valid with resp_valid.
- mem_we  output  1  to Memory write enable.
- mem_addr  output  32  to Memory address, always word aligned ({addr[31:2],2'b00}).
- mem_wdata  output  32  to Memory write data.
- mem_rdata  input  32  from Memory, combinational read data.

Behaviour:
- Reset: state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_addr=0, mem_wdata=0. req_ready=1 while in IDLE.
- Reset asserted mid-operation (any state) drops mem_we immediately, with no partial or merged write. Asserting reset in RMW_WR suppresses that write.
- States: IDLE, RD, RMW_WR, WR, RESP.
  - IDLE: req_ready=1. Accept when req_valid&&req_ready at a rising edge; latch we, funct3, addr, wdata.
  - Error check at accept, using the latched values:
    - misaligned: H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0;
    - illegal funct3: loads 3,6,7; stores >2;
    - range error when CHECK_RANGE=1.
  - On error -> RESP with err=1 and rdata=0; no memory access occurs.
  - Otherwise: loads -> RD; SW -> WR; SB/SH -> RD.
  - RD: mem_addr=aligned addr, mem_we=0.
    - Load: at the edge, capture the lane selected by addr[1:0] (B: byte lane addr[1:0]; H: half lane addr[1]), sign-extend for funct3 0/1, zero-extend for 4/5, W unchanged, into resp_rdata. Then -> RESP.
    - SB/SH: capture the merged word (mem_rdata with the target lane replaced by wdata[7:0] or wdata[15:0]) into a merge register. Then -> RMW_WR.
  - RMW_WR: mem_we=1, mem_wdata=merge register. -> RESP.
  - WR: mem_we=1, mem_wdata=latched wdata. -> RESP.
  - RESP: resp_valid=1 for exactly one cycle, req_ready=0. -> IDLE.
- Latency, counted in cycles after the accept edge:
  - resp_valid: LW/LB/LH = 2nd cycle; SW = 2nd; SB/SH = 3rd; error = 1st.
  - Throughput: one request per (latency+1) cycles. No back-to-back accept in RESP.
- mem_we is asserted in exactly one cycle per successful store and never for loads or errors.
- mem_addr/mem_wdata are held stable for the whole state. mem_wdata=0 outside write states.
- resp_rdata/resp_err are registered outputs and hold their value until the next RESP.

Decomposition:
- Shared package lsu_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), the state enum, and the lane-select helper.
- Sub-module lsu_lane_align: combinational load extract/extend plus store merge, keyed on funct3 and addr[1:0]. It is reused by the verification model.

Test Plan:
- Memory preloaded with word 4 = 0x8899AABB; LW addr 0x10 -> resp_rdata=0x8899AABB, resp_err=0, resp_valid 2 cycles after accept, mem_we never 1.
- LB addr 0x11 -> 0xFFFFFFAA; LBU 0x11 -> 0x000000AA; LH 0x12 -> 0xFFFF8899; LHU 0x12 -> 0x00008899.
- SB addr 0x13 wdata 0x12345677 -> one mem_we pulse in the 2nd cycle after accept; then word 4 = 0x7799AABB; resp_valid in the 3rd cycle after accept.
- SH addr 0x10 wdata 0x0000CAFE -> word 4 = 0x8899CAFE; SW 0x10 0xDEADBEEF -> word 4 = 0xDEADBEEF with a single mem_we cycle.
- LW 0x12, SH 0x11, LB with funct3=3, and LW 0x400 (CHECK_RANGE=1) -> each gives resp_err=1, resp_rdata=0, response 1 cycle after accept, no mem_we, memory unchanged.
- SB addr 0x20 with rst pulsed while in RMW_WR -> mem_we drops immediately, word 8 unchanged, outputs at reset values, req_ready=1 after reset release; a new LW then completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// and the byte-lane shift used by both load extraction and store merging.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RMW_WR,
    ST_WR,
    ST_RESP
  } lsu_state_e;

  // Bit offset of the addressed lane; halves only look at addr[1].
  function automatic logic [4:0] lane_shift(input logic [2:0] funct3,
                                            input logic [1:0] addr_lo);
    logic [4:0] sh;
    case (funct3[1:0])
      2'd0:    sh = {addr_lo, 3'b000};
      2'd1:    sh = {addr_lo[1], 4'b0000};
      default: sh = 5'd0;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane handling: extract/extend a load lane from a memory word,
// and merge a sub-word store into a memory word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [4:0]  sh;
  logic [31:0] lane;
  logic [31:0] mask;

  always_comb begin
    sh   = lane_shift(funct3, addr_lo);
    lane = rdata >> sh;
    case (funct3)
      F3_B:    load_data = {{24{lane[7]}}, lane[7:0]};
      F3_H:    load_data = {{16{lane[15]}}, lane[15:0]};
      F3_BU:   load_data = {24'd0, lane[7:0]};
      F3_HU:   load_data = {16'd0, lane[15:0]};
      default: load_data = rdata;
    endcase
    case (funct3[1:0])
      2'd0:    mask = 32'h0000_00FF << sh;
      2'd1:    mask = 32'h0000_FFFF << sh;
      default: mask = 32'hFFFF_FFFF;
    endcase
    merge_data = (rdata & ~mask) | ((wdata << sh) & mask);
  end

endmodule

// File: rtl/lsu_mem_master.sv
// MEM-stage load/store unit: one outstanding request, word-only memory port,
// sub-word stores done as read-modify-write.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   IDLE      | ready for a request; errors go straight to RESP
//   RD        | memory word read; load result or store merge captured
//   RMW_WR    | merged word written back (SB/SH)
//   WR        | full word written (SW)
//   RESP      | one-cycle completion pulse to the pipeline
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS_LOG2 = 8,
  parameter bit CHECK_RANGE    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state, state_nxt;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;
  logic [31:0] load_data;
  logic [31:0] merge_data;
  logic        accept;
  logic        misalign;
  logic        illegal;
  logic        range_err;
  logic        req_err;

  assign accept = req_valid && req_ready;

  always_comb begin
    misalign  = (req_funct3[1:0] == 2'd1 && req_addr[0]) ||
                (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'd0);
    illegal   = req_we ? (req_funct3 > F3_W)
                       : (req_funct3 == 3'd3 || req_funct3[2:1] == 2'b11);
    range_err = CHECK_RANGE && (req_addr[31:MEM_WORDS_LOG2+2] != '0);
    req_err   = misalign || illegal || range_err;
  end

  lsu_lane_align u_align (
    .funct3     (funct3_q),
    .addr_lo    (addr_q[1:0]),
    .rdata      (mem_rdata),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (req_err)                     state_nxt = ST_RESP;
          else if (req_we && req_funct3 == F3_W) state_nxt = ST_WR;
          else                             state_nxt = ST_RD;
        end
      end
      ST_RD:     state_nxt = we_q ? ST_RMW_WR : ST_RESP;
      ST_RMW_WR: state_nxt = ST_RESP;
      ST_WR:     state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = 32'd0;
    case (state)
      ST_IDLE:   req_ready = 1'b1;
      ST_RMW_WR: begin mem_we = 1'b1; mem_wdata = merge_q; end
      ST_WR:     begin mem_we = 1'b1; mem_wdata = wdata_q; end
      ST_RESP:   resp_valid = 1'b1;
      default:   ;
    endcase
  end

  assign mem_addr = {addr_q[31:2], 2'b00};

  // Response registers only change on the edge entering RESP, so they hold
  // the previous result while a new request is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q       <= 1'b0;
      funct3_q   <= 3'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      merge_q    <= 32'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        if (req_err) begin
          resp_err   <= 1'b1;
          resp_rdata <= 32'd0;
        end
      end
      case (state)
        ST_RD: begin
          if (we_q) merge_q <= merge_data;
          else begin
            resp_rdata <= load_data;
            resp_err   <= 1'b0;
          end
        end
        ST_RMW_WR, ST_WR: begin
          resp_rdata <= 32'd0;
          resp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a small word memory attached.
module tb_lsu_mem_master;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [256];
  logic        bd_we;
  logic [7:0]  bd_idx;
  logic [31:0] bd_data;

  int checks = 0;
  int errors = 0;
  int lat, wes, we_at;
  logic [31:0] rd;
  logic        er;

  always #5 clk = ~clk;

  lsu_mem_master #(.MEM_WORDS_LOG2(8), .CHECK_RANGE(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (bd_we)       mem[bd_idx] <= bd_data;
    else if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] idx, input logic [31:0] data);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = idx; bd_data = data;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Issues one request; returns response cycle (after accept), mem_we cycle
  // count and the cycle of the last mem_we, plus the response data.
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, output int l, output int w, output int wa,
                      output logic [31:0] r, output logic e);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    l = 99; w = 0; wa = 0; r = 32'hx; e = 1'bx;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_we) begin w++; wa = c; end
      if (resp_valid) begin
        l = c; r = resp_rdata; e = resp_err;
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; bd_we = 1'b0; bd_idx = 8'd0; bd_data = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", {31'd0, resp_err}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;

    poke(8'd4, 32'h8899AABB);
    poke(8'd8, 32'h11223344);

    xact(1'b0, F3_W, 32'h10, 32'd0, lat, wes, we_at, rd, er);
    check("lw_rdata", rd, 32'h8899AABB);
    check("lw_err", {31'd0, er}, 32'd0);
    check("lw_lat", lat, 2);
    check("lw_we", wes, 0);

    xact(1'b0, F3_B, 32'h11, 32'd0, lat, wes, we_at, rd, er);
    check("lb_rdata", rd, 32'hFFFFFFAA);
    check("lb_lat", lat, 2);
    xact(1'b0, F3_BU, 32'h11, 32'd0, lat, wes, we_at, rd, er);
    check("lbu_rdata", rd, 32'h000000AA);
    xact(1'b0, F3_H, 32'h12, 32'd0, lat, wes, we_at, rd, er);
    check("lh_rdata", rd, 32'hFFFF8899);
    xact(1'b0, F3_HU, 32'h12, 32'd0, lat, wes, we_at, rd, er);
    check("lhu_rdata", rd, 32'h00008899);
    check("lhu_err", {31'd0, er}, 32'd0);
    check("hold_rdata", resp_rdata, 32'h00008899);

    xact(1'b1, F3_B, 32'h13, 32'h12345677, lat, wes, we_at, rd, er);
    check("sb_lat", lat, 3);
    check("sb_we_cnt", wes, 1);
    check("sb_we_cyc", we_at, 2);
    check("sb_rdata", rd, 32'd0);
    check("sb_mem", mem[4], 32'h7799AABB);

    poke(8'd4, 32'h8899AABB);
    xact(1'b1, F3_H, 32'h10, 32'h0000CAFE, lat, wes, we_at, rd, er);
    check("sh_mem", mem[4], 32'h8899CAFE);
    check("sh_we_cnt", wes, 1);
    check("sh_lat", lat, 3);

    xact(1'b1, F3_W, 32'h10, 32'hDEADBEEF, lat, wes, we_at, rd, er);
    check("sw_mem", mem[4], 32'hDEADBEEF);
    check("sw_we_cnt", wes, 1);
    check("sw_we_cyc", we_at, 1);
    check("sw_lat", lat, 2);

    xact(1'b0, F3_W, 32'h12, 32'd0, lat, wes, we_at, rd, er);
    check("lw_mis_err", {31'd0, er}, 32'd1);
    check("lw_mis_rdata", rd, 32'd0);
    check("lw_mis_lat", lat, 1);
    check("lw_mis_we", wes, 0);

    xact(1'b1, F3_H, 32'h11, 32'h0000BEEF, lat, wes, we_at, rd, er);
    check("sh_mis_err", {31'd0, er}, 32'd1);
    check("sh_mis_lat", lat, 1);
    check("sh_mis_we", wes, 0);

    xact(1'b0, 3'd3, 32'h10, 32'd0, lat, wes, we_at, rd, er);
    check("f3_ill_err", {31'd0, er}, 32'd1);
    check("f3_ill_rdata", rd, 32'd0);
    check("f3_ill_lat", lat, 1);

    xact(1'b0, F3_W, 32'h400, 32'd0, lat, wes, we_at, rd, er);
    check("range_err", {31'd0, er}, 32'd1);
    check("range_lat", lat, 1);
    check("range_we", wes, 0);
    check("err_mem", mem[4], 32'hDEADBEEF);

    // Reset while the merged write is being presented.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_B; req_addr = 32'h20; req_wdata = 32'h000000EE;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rmw_we", {31'd0, mem_we}, 32'd1);
    check("rmw_wdata", mem_wdata, 32'h112233EE);
    rst = 1'b1;
    #1;
    check("rstmid_we", {31'd0, mem_we}, 32'd0);
    check("rstmid_wdata", mem_wdata, 32'd0);
    check("rstmid_addr", mem_addr, 32'd0);
    check("rstmid_rdata", resp_rdata, 32'd0);
    check("rstmid_err", {31'd0, resp_err}, 32'd0);
    check("rstmid_valid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstmid_ready", {31'd0, req_ready}, 32'd1);
    check("rstmid_mem", mem[8], 32'h11223344);

    xact(1'b0, F3_W, 32'h20, 32'd0, lat, wes, we_at, rd, er);
    check("post_lw_rdata", rd, 32'h11223344);
    check("post_lw_err", {31'd0, er}, 32'd0);
    check("post_lw_lat", lat, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
